// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable sequence detector:
//   - DEF_PATTERN_W3_L8 : reset pattern for the W=3 / LEN=8 build
//   - default mask bit and default match mode
//   - match_mode_e      : overlapping / non-overlapping selection
//   - pat_symbol()      : extracts symbol k from a packed pattern bus
// ---------------------------------------------------------------------------
package seq_det_pkg;

  // Upper bounds on sizing; the pattern helper works on a fixed-width bus.
  localparam int MAX_LEN      = 32;
  localparam int MAX_W        = 32;
  localparam int PAT_MAX_BITS = 1024;

  // Symbol k sits at bits [k*3 +: 3], so the first symbol in time is the
  // rightmost field. First-to-last: 001,101,110,000,110,110,011,101.
  localparam logic [23:0] DEF_PATTERN_W3_L8 = {
    3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001
  };

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } match_mode_e;

  localparam logic        DEF_MASK_BIT = 1'b1;   // every symbol compared
  localparam match_mode_e DEF_MODE     = MODE_OVERLAP;

  typedef logic [PAT_MAX_BITS-1:0] pat_bus_t;

  // Returns symbol k (width w) of a packed pattern, zero-extended to MAX_W.
  // A shift of 32 yields zero, so the w=32 mask correctly becomes all ones.
  function automatic logic [MAX_W-1:0] pat_symbol(input pat_bus_t pat,
                                                  input int w,
                                                  input int k);
    pat_bus_t sh;
    sh = pat >> (k * w);
    return sh[MAX_W-1:0] & ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/seq_window.sv
// ---------------------------------------------------------------------------
// seq_window
// History of the last LEN qualified symbols plus a fill counter.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   i_shift   : push i_data into the window this cycle
//   i_flush   : restart the fill count (wins over the shift for the count)
//   i_data    : incoming symbol
//   o_recent  : newest LEN-1 stored symbols, slot j (0 = newest) at [j*W +: W]
//   o_fill    : number of symbols held since the last flush, saturates at LEN
//   o_full    : registered (fill == LEN)
// ---------------------------------------------------------------------------
module seq_window #(
  parameter int W   = 3,
  parameter int LEN = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_shift,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_data,
  output logic [(LEN-1)*W-1:0]       o_recent,
  output logic [$clog2(LEN+1)-1:0]   o_fill,
  output logic                       o_full
);

  localparam int FILL_W = $clog2(LEN+1);

  logic [W-1:0]      r_win [LEN];
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_next;
  logic              r_full;

  // One register per window slot; slot 0 takes the new symbol.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_slot
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_win[gi] <= '0;
      end else if (i_shift) begin
        if (gi == 0) begin
          r_win[gi] <= i_data;
        end else begin
          r_win[gi] <= r_win[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  end

  for (genvar gi = 0; gi < LEN - 1; gi++) begin : g_recent
    assign o_recent[gi*W +: W] = r_win[gi];
  end

  // Stale slot contents after a flush are harmless: the fill count gates
  // every compare, so only the counter needs restarting.
  always_comb begin
    w_fill_next = r_fill;
    if (i_flush) begin
      w_fill_next = '0;
    end else if (i_shift && (r_fill != FILL_W'(LEN))) begin
      w_fill_next = r_fill + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= '0;
      r_full <= 1'b0;
    end else begin
      r_fill <= w_fill_next;
      r_full <= (w_fill_next == FILL_W'(LEN));
    end
  end

  assign o_fill = r_fill;
  assign o_full = r_full;

endmodule

// File: rtl/seq_detector_prog.sv
// ---------------------------------------------------------------------------
// seq_detector_prog
// Runtime-programmable streaming detector for a LEN-symbol pattern of W-bit
// symbols with per-symbol don't-care mask, overlap control and a saturating
// match counter.
// Ports:
//   clk, reset_n    : clock (rising edge), asynchronous active-low reset
//   data/data_valid : qualified symbol stream
//   cfg_we          : load cfg_pattern/cfg_mask/cfg_overlap, flush history;
//                     the symbol presented in that cycle is dropped
//   cfg_pattern     : symbol k (k=0 first in time) at [k*W +: W]
//   cfg_mask        : bit k=1 compares symbol k, 0 = don't care
//   cfg_overlap     : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clear       : synchronous clear of match_count (wins over a match)
//   sequence_found  : one-cycle pulse, the cycle after the final symbol
//   match_count     : saturating match count
//   hist_full       : window holds LEN symbols since the last flush
// ---------------------------------------------------------------------------
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int W     = 3,
  parameter int LEN   = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [W-1:0]       data,
  input  logic               data_valid,
  input  logic               cfg_we,
  input  logic [LEN*W-1:0]   cfg_pattern,
  input  logic [LEN-1:0]     cfg_mask,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               sequence_found,
  output logic [CNT_W-1:0]   match_count,
  output logic               hist_full
);

  localparam int PW     = LEN * W;
  localparam int FILL_W = $clog2(LEN+1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (LEN < 2 || LEN > MAX_LEN) begin : g_len_check
    $error("seq_detector_prog: LEN must be in 2..32");
  end
  if (W < 1 || W > MAX_W) begin : g_w_check
    $error("seq_detector_prog: W must be in 1..32");
  end

  // Only the W=3 / LEN=8 build has a named reset pattern; other sizes come
  // out of reset with an all-zero pattern and are expected to be programmed.
  function automatic logic [PW-1:0] f_def_pattern();
    logic [PW-1:0] v;
    v = '0;
    if (W == 3 && LEN == 8) begin
      v = PW'(DEF_PATTERN_W3_L8);
    end
    return v;
  endfunction

  localparam logic [PW-1:0] P_DEF_PATTERN = f_def_pattern();

  logic [PW-1:0]           r_pattern;
  logic [LEN-1:0]          r_mask;
  match_mode_e             r_overlap;
  logic                    r_found;
  logic [CNT_W-1:0]        r_count;

  logic                    w_accept;
  logic                    w_flush;
  logic                    w_match;
  logic                    w_fill_ok;
  logic [LEN-1:0]          w_sym_ok;
  logic [(LEN-1)*W-1:0]    w_recent;
  logic [FILL_W-1:0]       w_fill;
  logic                    w_full;
  pat_bus_t                w_pat_ext;

  // Configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= P_DEF_PATTERN;
      r_mask    <= {LEN{DEF_MASK_BIT}};
      r_overlap <= DEF_MODE;
    end else if (cfg_we) begin
      r_pattern <= cfg_pattern;
      r_mask    <= cfg_mask;
      r_overlap <= match_mode_e'(cfg_overlap);
    end
  end

  // A config write swallows the symbol presented alongside it.
  assign w_accept = data_valid & ~cfg_we;

  // Non-overlap mode restarts the fill count so the next hit needs LEN
  // fresh symbols.
  assign w_flush = cfg_we | (w_match & (r_overlap == MODE_NONOVERLAP));

  seq_window #(
    .W   (W),
    .LEN (LEN)
  ) u_window (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_shift  (w_accept),
    .i_flush  (w_flush),
    .i_data   (data),
    .o_recent (w_recent),
    .o_fill   (w_fill),
    .o_full   (w_full)
  );

  // Masked comparator: the incoming symbol is pattern symbol LEN-1, stored
  // slot j (0 = newest) lines up with pattern symbol LEN-2-j.
  assign w_pat_ext = PAT_MAX_BITS'(r_pattern);

  for (genvar gi = 0; gi < LEN; gi++) begin : g_cmp
    logic [W-1:0] w_cand;
    logic [W-1:0] w_expect;
    if (gi == LEN - 1) begin : g_live
      assign w_cand = data;
    end else begin : g_stored
      assign w_cand = w_recent[(LEN-2-gi)*W +: W];
    end
    assign w_expect     = W'(pat_symbol(w_pat_ext, W, gi));
    assign w_sym_ok[gi] = ~r_mask[gi] | (w_cand == w_expect);
  end

  assign w_fill_ok = (w_fill >= FILL_W'(LEN - 1));
  assign w_match   = w_accept & w_fill_ok & (&w_sym_ok);

  // Match pulse and saturating counter; a clear beats a coincident match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_found <= 1'b0;
      r_count <= '0;
    end else begin
      r_found <= w_match;
      if (cnt_clear) begin
        r_count <= '0;
      end else if (w_match && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign sequence_found = r_found;
  assign match_count    = r_count;
  assign hist_full      = w_full;

endmodule
